mdu_iterative: RTL and testbench
================================

# mdu_iterative

Iterative multiply/divide unit sitting beside the single-cycle ALU in the execute path. It consumes the same 32-bit register operands A and B that feed the ALU and produces a 64-bit result into dedicated HI/LO registers, which write-back reads through its mfhi/mflo path. Operations take a fixed multi-cycle latency behind a start/busy/done handshake; the control unit stalls the PC while `busy` is high.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits; the iteration count equals `WIDTH`.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request a new operation; sampled only when `busy`=0.
- `op`  input  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `A`  input  WIDTH  multiplicand / dividend, captured at the accepting edge.
- `B`  input  WIDTH  multiplier / divisor, captured at the accepting edge.
- `busy`  output  1  high from the accepting edge until the result is written.
- `done`  output  1  one-cycle pulse in the cycle after HI/LO update.
- `dz`  output  1  divide-by-zero flag for the last completed operation; valid with `done`, held until next accept.
- `hi`  output  WIDTH  HI register (product upper half / remainder).
- `lo`  output  WIDTH  LO register (product lower half / quotient).

## Operation
- States: IDLE, RUN, FIN.
- IDLE: when `start`=1, capture `op`, A, B; for signed ops take magnitudes and record result signs; clear the iteration counter; go to RUN.
- RUN: exactly `WIDTH` iterations, one per cycle. Multiply: shift-add on the 2*WIDTH accumulator. Divide: restoring shift-subtract on the remainder/quotient pair. After iteration `WIDTH`, go to FIN.
- FIN: apply sign fix-up, write HI/LO, set `dz`, return to IDLE, pulse `done`.
- MULT/MULTU: {hi,lo} = full 2*WIDTH product. MULT is two's-complement signed.
- DIVU/DIV: lo = quotient, hi = remainder. DIV truncates toward zero; remainder takes the dividend's sign.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, `dz`=0. No trap.
- Divide with B=0: latency unchanged; lo=0xFFFFFFFF, hi=A (original, unsigned view), `dz`=1.
- `dz`=0 after any multiply.
- `start` while `busy`=1 is ignored; operands are not re-captured.
- HI/LO change only in FIN. They hold their values across IDLE and RUN, so mfhi/mflo during a RUN returns the previous result.

## Timing
- Reset (async assert, any state): state=IDLE, `busy`=0, `done`=0, `dz`=0, hi=0, lo=0, counter=0. An in-flight operation is discarded.
- Reset release: first accept is possible at the first rising edge with `rst_n`=1.
- Accepting edge E0: `busy`=1 after E0.
- RUN iterations occupy edges E1..E`WIDTH`.
- FIN edge E(`WIDTH`+1): HI/LO/`dz` are updated, `busy`=0, and `done`=1 for exactly one cycle.
- Latency: result visible 33 cycles after the accepting edge (WIDTH=32).
- `start`=1 in the same cycle `done`=1 is accepted, giving back-to-back throughput of one operation per 33 cycles.

## Configuration
- `MDU_SIGNED_EN` defined: MULT and DIV perform the signed magnitude/fix-up handling described above.
- `MDU_SIGNED_EN` undefined: `op[0]` is ignored and the sign logic is not compiled. MULT behaves as MULTU; DIV behaves as DIVU. Latency is identical.

## Test plan
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, `done` pulse of 1 cycle, `dz`=0.
- MULT A=-3 B=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Without `MDU_SIGNED_EN`: hi=0x00000004, lo=0xFFFFFFF1.
- DIV A=-7 B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=100 B=7 -> lo=14, hi=2.
- DIVU A=0x1234 B=0 -> lo=0xFFFFFFFF, hi=0x1234, `dz`=1, latency still 33.
- Start MULTU 6*7. Pulse `start` with MULTU 2*2 at cycle 10. Result: hi=0, lo=42 at cycle 33, second request ignored. Start again in the `done` cycle -> accepted, `busy` is high on the next cycle.
- Start DIVU, assert `rst_n`=0 at cycle 15 -> `busy`, `done`, hi, and lo are immediately 0. After release, a new MULTU 3*3 gives lo=9 at latency 33.

Source files
------------

// File: rtl/mdu_iterative.sv
// Iterative MULT/MULTU/DIV/DIVU unit: 32 shift-add / restoring-divide steps, result in HI/LO after WIDTH+1 cycles.
// Optional macro MDU_SIGNED_EN compiles the signed magnitude/fix-up path; otherwise op[0] is ignored.
module mdu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;
    localparam int         CW     = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] w_q, w_d;      // {acc_hi, multiplier} or {remainder, dividend/quotient}
    logic [WIDTH-1:0]   b_q, b_d;      // multiplicand or divisor magnitude
    logic               div_q, div_d;
    logic               dzp_q, dzp_d;
    logic               negq_q, negq_d;
    logic               negr_q, negr_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dz_q, dz_d;
    logic               done_q, done_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   a_mag, b_mag;

`ifdef MDU_SIGNED_EN
    assign sa    = op[0] & A[WIDTH-1];
    assign sb    = op[0] & B[WIDTH-1];
    assign a_mag = sa ? -A : A;
    assign b_mag = sb ? -B : B;
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign sa    = 1'b0;
    assign sb    = 1'b0;
    assign a_mag = A;
    assign b_mag = B;
`endif

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic [WIDTH:0]       div_diff;
    logic [WIDTH-1:0]     fin_q;
    logic [WIDTH-1:0]     fin_r;
    logic [2*WIDTH-1:0]   fin_p;

    assign mul_sum   = {1'b0, w_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};
    assign div_shift = w_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, b_q};

    always_comb begin
        fin_q = w_q[WIDTH-1:0];
        fin_r = w_q[2*WIDTH-1:WIDTH];
        fin_p = w_q;
`ifdef MDU_SIGNED_EN
        if (negq_q) begin
            fin_q = -w_q[WIDTH-1:0];
            fin_p = -w_q;
        end
        if (negr_q) begin
            fin_r = -w_q[2*WIDTH-1:WIDTH];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        b_d     = b_q;
        div_d   = div_q;
        dzp_d   = dzp_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    div_d   = op[1];
                    dzp_d   = op[1] && (B == '0);
                    negq_d  = sa ^ sb;
                    negr_d  = sa;
                    // Divide holds the dividend low; multiply holds the multiplier low.
                    w_d     = op[1] ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                    b_d     = op[1] ? b_mag : a_mag;
                end
            end
            S_RUN: begin
                if (div_q) begin
                    if (!div_diff[WIDTH]) begin
                        w_d = {div_diff[WIDTH-1:0], w_q[WIDTH-2:0], 1'b1};
                    end else begin
                        w_d = {div_shift[WIDTH-1:0], w_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    if (w_q[0]) begin
                        w_d = {mul_sum, w_q[WIDTH-1:1]};
                    end else begin
                        w_d = {1'b0, w_q[2*WIDTH-1:1]};
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                if (div_q) begin
                    // A zero divisor leaves remainder = |A|; the remainder fix-up restores A itself.
                    lo_d = dzp_q ? {WIDTH{1'b1}} : fin_q;
                    hi_d = fin_r;
                    dz_d = dzp_q;
                end else begin
                    {hi_d, lo_d} = fin_p;
                    dz_d = 1'b0;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            w_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            dzp_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            b_q     <= b_d;
            div_q   <= div_d;
            dzp_q   <= dzp_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign dz   = dz_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: latency, handshake, HI/LO hold, divide-by-zero, reset abort.
module tb_mdu_iterative;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        busy, done, dz;
    logic [31:0] hi, lo;

    int ncmp = 0;
    int nfail = 0;
    int lat;

`ifdef MDU_SIGNED_EN
    localparam logic [31:0] MULT_HI  = 32'hFFFF_FFFF;
    localparam logic [31:0] DIV7_LO  = 32'hFFFF_FFFD;
    localparam logic [31:0] DIV7_HI  = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_LO   = 32'h8000_0000;
    localparam logic [31:0] OVF_HI   = 32'h0000_0000;
`else
    localparam logic [31:0] MULT_HI  = 32'h0000_0004;
    localparam logic [31:0] DIV7_LO  = 32'h7FFF_FFFC;
    localparam logic [31:0] DIV7_HI  = 32'h0000_0001;
    localparam logic [31:0] OVF_LO   = 32'h0000_0000;
    localparam logic [31:0] OVF_HI   = 32'h8000_0000;
`endif

    mdu_iterative #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .dz    (dz),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the accepting edge until done is seen; optionally pokes start at cycle 10.
    task automatic wait_done(input string tag, input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                             input bit poke, output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 10) begin
                chk({tag, "_hold_hi"}, hi, prev_hi);
                chk({tag, "_hold_lo"}, lo, prev_lo);
                chk({tag, "_busy_run"}, {31'b0, busy}, 32'd1);
                if (poke) begin
                    start = 1'b1;
                    op    = 2'b00;
                    A     = 32'd2;
                    B     = 32'd2;
                end
            end
            if (n == 11) start = 1'b0;
        end while (!done && n < 60);
        chk({tag, "_latency"}, 32'(n), 32'd33);
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] prev_hi, input logic [31:0] prev_lo,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input logic exp_dz);
        int n;
        issue(o, a, b);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        wait_done(tag, prev_hi, prev_lo, 1'b0, n);
        chk({tag, "_hi"}, hi, exp_hi);
        chk({tag, "_lo"}, lo, exp_lo);
        chk({tag, "_dz"}, {31'b0, dz}, {31'b0, exp_dz});
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
        chk({tag, "_dz_hold"}, {31'b0, dz}, {31'b0, exp_dz});
    endtask

    initial begin
        #2;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_dz",   {31'b0, dz},   32'd0);
        chk("rst_hi",   hi, 32'd0);
        chk("rst_lo",   lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'h0, 32'h0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_m3x5", 2'b01, 32'hFFFF_FFFD, 32'd5,
               32'hFFFF_FFFE, 32'h0000_0001, MULT_HI, 32'hFFFF_FFF1, 1'b0);
        run_op("div_m7d2", 2'b11, 32'hFFFF_FFF9, 32'd2,
               MULT_HI, 32'hFFFF_FFF1, DIV7_HI, DIV7_LO, 1'b0);
        run_op("divu_100d7", 2'b10, 32'd100, 32'd7,
               DIV7_HI, DIV7_LO, 32'd2, 32'd14, 1'b0);
        run_op("divu_dz", 2'b10, 32'h0000_1234, 32'd0,
               32'd2, 32'd14, 32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_1234, 32'hFFFF_FFFF, OVF_HI, OVF_LO, 1'b0);
        run_op("div_neg_dz", 2'b11, 32'hFFFF_FFF8, 32'd0,
               OVF_HI, OVF_LO, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1);

        // Second start during RUN must be ignored, then a start in the done cycle is accepted.
        issue(2'b00, 32'd6, 32'd7);
        wait_done("ign", 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1, lat);
        chk("ign_hi", hi, 32'd0);
        chk("ign_lo", lo, 32'd42);
        chk("ign_dz", {31'b0, dz}, 32'd0);
        chk("ign_done", {31'b0, done}, 32'd1);
        start = 1'b1;
        op    = 2'b00;
        A     = 32'd2;
        B     = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_done_low", {31'b0, done}, 32'd0);
        wait_done("b2b", 32'd0, 32'd42, 1'b0, lat);
        chk("b2b_lo", lo, 32'd4);
        chk("b2b_hi", hi, 32'd0);

        // Asynchronous reset in the middle of a divide.
        issue(2'b10, 32'd100, 32'd7);
        repeat (14) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'b0, busy}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd4 - 32'd4);
        chk("arst_dz", {31'b0, dz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 2'b00, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 32'd9, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
